arcade_input_ctrl: RTL

Parametrised keyboard/joystick input controller for the arcade cores. It sits between `hps_io` and the game core and decodes MiSTer 65-bit `ps2_key` events into per-player button states. It merges those states with the HPS joysticks and applies screen-rotation remapping to the direction bits. It also adds two things the current per-core inline decoders lack: a timed coin-pulse state machine and frame-locked autofire.

---
 rtl/arcade_input_pkg.sv | 93 +++++++++
 rtl/coin_pulser.sv | 58 +++++
 rtl/arcade_input_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/arcade_input_pkg.sv
// Shared constants and helpers for the arcade keyboard/joystick input controller.
package arcade_input_pkg;

  // Screen rotation applied to the direction bits
  typedef enum logic [1:0] {
    ROT_NONE = 2'd0,
    ROT_CW   = 2'd1,
    ROT_180  = 2'd2,
    ROT_CCW  = 2'd3
  } rot_e;

  // Coin pulse sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2
  } coin_st_e;

  // Bit positions inside one player's 6-bit button group
  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_FIRE  = 4;
  localparam int unsigned BTN_START = 5;

  // Bit positions inside an HPS joystick word
  localparam int unsigned JOY_RIGHT = 0;
  localparam int unsigned JOY_LEFT  = 1;
  localparam int unsigned JOY_DOWN  = 2;
  localparam int unsigned JOY_UP    = 3;
  localparam int unsigned JOY_FIRE  = 4;
  localparam int unsigned JOY_START = 5;
  localparam int unsigned JOY_COIN  = 7;

  // Index of each key-state flop
  localparam int unsigned K1_UP     = 0;
  localparam int unsigned K1_DOWN   = 1;
  localparam int unsigned K1_LEFT   = 2;
  localparam int unsigned K1_RIGHT  = 3;
  localparam int unsigned K1_FIRE_A = 4;
  localparam int unsigned K1_FIRE_B = 5;
  localparam int unsigned K1_START  = 6;
  localparam int unsigned K1_COIN   = 7;
  localparam int unsigned K2_UP     = 8;
  localparam int unsigned K2_DOWN   = 9;
  localparam int unsigned K2_LEFT   = 10;
  localparam int unsigned K2_RIGHT  = 11;
  localparam int unsigned K2_FIRE   = 12;
  localparam int unsigned K2_START  = 13;
  localparam int unsigned K2_COIN   = 14;
  localparam int unsigned NUM_KEYS  = 15;

  // Player-1 arrows match on the low byte only (extended flag ignored)
  localparam logic [7:0] SC_ARROW_UP    = 8'h75;
  localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
  localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
  localparam logic [8:0] SC_P1_FIRE_A   = 9'h029;
  localparam logic [8:0] SC_P1_FIRE_B   = 9'h014;
  localparam logic [8:0] SC_P1_START    = 9'h005;
  localparam logic [8:0] SC_P1_COIN     = 9'h02E;
  localparam logic [8:0] SC_P2_UP       = 9'h02D;
  localparam logic [8:0] SC_P2_DOWN     = 9'h02B;
  localparam logic [8:0] SC_P2_LEFT     = 9'h023;
  localparam logic [8:0] SC_P2_RIGHT    = 9'h034;
  localparam logic [8:0] SC_P2_FIRE     = 9'h01C;
  localparam logic [8:0] SC_P2_START    = 9'h006;
  localparam logic [8:0] SC_P2_COIN     = 9'h036;

  // Remap directions {right, left, down, up} for the given screen rotation
  function automatic logic [3:0] rot_dirs(input logic [3:0] d, input rot_e rot);
    logic [3:0] o;
    case (rot)
      ROT_CW:  o = {d[0], d[1], d[3], d[2]};
      ROT_180: o = {d[2], d[3], d[0], d[1]};
      ROT_CCW: o = {d[1], d[0], d[2], d[3]};
      default: o = d;
    endcase
    return o;
  endfunction

  // Rotate directions and gate fire; start passes through
  function automatic logic [5:0] shape_btn(input logic [5:0] raw, input rot_e rot,
                                           input logic fire_gate);
    logic [5:0] s;
    s = raw;
    s[3:0] = rot_dirs(raw[3:0], rot);
    s[BTN_FIRE] = raw[BTN_FIRE] & fire_gate;
    return s;
  endfunction

endpackage

// File: rtl/coin_pulser.sv
// Turns the rising edge of a coin request into a fixed-width pulse followed by an equal hold-off.
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter logic [15:0] COIN_PULSE = 16'd3000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic req,
  output logic pulse
);

  coin_st_e    state;
  logic [15:0] cnt;
  logic        req_q;

  // Edge register reloads even in reset so a request held across release never fires
  always_ff @(posedge clk_sys) begin
    req_q <= req;
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !req_q) begin
            state <= PULSE;
            cnt   <= COIN_PULSE - 16'd1;
            pulse <= 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            state <= HOLD;
            cnt   <= COIN_PULSE - 16'd1;
            pulse <= 1'b0;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          pulse <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Keyboard/joystick input controller: ps2_key decode, joystick merge, rotation, autofire, coin pulse.
module arcade_input_ctrl
  import arcade_input_pkg::*;
#(
  parameter int          PLAYERS         = 2,
  parameter logic [15:0] COIN_PULSE      = 16'd3000,
  parameter logic [3:0]  AUTOFIRE_FRAMES = 4'd3,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [64:0]            ps2_key,
  input  logic [15:0]            joystick_0,
  input  logic [15:0]            joystick_1,
  input  logic [1:0]             rotate,
  input  logic                   autofire_en,
  input  logic                   vblank,
  output logic [6*PLAYERS-1:0]   btn_o,
  output logic                   coin_o
);

  localparam int BW = 6 * PLAYERS;

  logic                pressed;
  logic                extended;
  logic [8:0]          code;
  logic [NUM_KEYS-1:0] key_hit;
  logic [NUM_KEYS-1:0] keys;
  logic                tog;
  logic [5:0]          raw1;
  logic [5:0]          raw2;
  logic [BW-1:0]       btn_n;
  logic                coin_req;
  logic                coin_pulse;
  logic                vblank_q;
  logic [3:0]          af_cnt;
  logic                af_phase;
  logic                fire_gate;
  rot_e                rot;
  logic                unused_joy;

  assign unused_joy = &{joystick_0[15:8], joystick_0[6], joystick_1[15:8], joystick_1[6]};
  assign rot = rot_e'(rotate);

  // Decode the current ps2_key word into a 9-bit code and the keys it matches
  always_comb begin
    pressed  = (ps2_key[15:8] != 8'hF0);
    extended = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
    code     = (|ps2_key[63:24]) ? '0 : {extended, ps2_key[7:0]};
    key_hit  = '0;
    key_hit[K1_UP]     = (code[7:0] == SC_ARROW_UP);
    key_hit[K1_DOWN]   = (code[7:0] == SC_ARROW_DOWN);
    key_hit[K1_LEFT]   = (code[7:0] == SC_ARROW_LEFT);
    key_hit[K1_RIGHT]  = (code[7:0] == SC_ARROW_RIGHT);
    key_hit[K1_FIRE_A] = (code == SC_P1_FIRE_A);
    key_hit[K1_FIRE_B] = (code == SC_P1_FIRE_B);
    key_hit[K1_START]  = (code == SC_P1_START);
    key_hit[K1_COIN]   = (code == SC_P1_COIN);
    key_hit[K2_UP]     = (code == SC_P2_UP);
    key_hit[K2_DOWN]   = (code == SC_P2_DOWN);
    key_hit[K2_LEFT]   = (code == SC_P2_LEFT);
    key_hit[K2_RIGHT]  = (code == SC_P2_RIGHT);
    key_hit[K2_FIRE]   = (code == SC_P2_FIRE);
    key_hit[K2_START]  = (code == SC_P2_START);
    key_hit[K2_COIN]   = (code == SC_P2_COIN);
  end

  // Key-state flops update on each toggle flip; toggle register tracks input through reset
  always_ff @(posedge clk_sys) begin
    tog <= ps2_key[64];
    if (reset) begin
      keys <= '0;
    end else if (ps2_key[64] != tog) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (key_hit[i]) keys[i] <= pressed;
      end
    end
  end

  // Per-player raw button state: key state OR joystick bit
  always_comb begin
    raw1 = '0;
    raw2 = '0;
    raw1[BTN_UP]    = keys[K1_UP]    | joystick_0[JOY_UP];
    raw1[BTN_DOWN]  = keys[K1_DOWN]  | joystick_0[JOY_DOWN];
    raw1[BTN_LEFT]  = keys[K1_LEFT]  | joystick_0[JOY_LEFT];
    raw1[BTN_RIGHT] = keys[K1_RIGHT] | joystick_0[JOY_RIGHT];
    raw1[BTN_FIRE]  = keys[K1_FIRE_A] | keys[K1_FIRE_B] | joystick_0[JOY_FIRE];
    raw1[BTN_START] = keys[K1_START] | joystick_0[JOY_START];
    raw2[BTN_UP]    = keys[K2_UP]    | joystick_1[JOY_UP];
    raw2[BTN_DOWN]  = keys[K2_DOWN]  | joystick_1[JOY_DOWN];
    raw2[BTN_LEFT]  = keys[K2_LEFT]  | joystick_1[JOY_LEFT];
    raw2[BTN_RIGHT] = keys[K2_RIGHT] | joystick_1[JOY_RIGHT];
    raw2[BTN_FIRE]  = keys[K2_FIRE]  | joystick_1[JOY_FIRE];
    raw2[BTN_START] = keys[K2_START] | joystick_1[JOY_START];
    coin_req = keys[K1_COIN] | keys[K2_COIN] | keys[K1_START] | keys[K2_START]
             | joystick_0[JOY_COIN] | joystick_1[JOY_COIN]
             | joystick_0[JOY_START] | joystick_1[JOY_START];
  end

  // Frame-locked autofire phase, held high and reset to frame 0 while disabled
  always_ff @(posedge clk_sys) begin
    vblank_q <= vblank;
    if (reset || !autofire_en) begin
      af_cnt   <= '0;
      af_phase <= 1'b1;
    end else if (vblank && !vblank_q) begin
      if (af_cnt == AUTOFIRE_FRAMES - 4'd1) begin
        af_cnt   <= '0;
        af_phase <= ~af_phase;
      end else begin
        af_cnt <= af_cnt + 4'd1;
      end
    end
  end

  // Gate directly on the enable so disabling autofire releases fire on the next output edge
  assign fire_gate = af_phase | ~autofire_en;

  if (PLAYERS == 1) begin : g_one
    assign btn_n = shape_btn(raw1 | raw2, rot, fire_gate);
  end else begin : g_two
    assign btn_n = {shape_btn(raw2, rot, fire_gate), shape_btn(raw1, rot, fire_gate)};
  end

  coin_pulser #(
    .COIN_PULSE(COIN_PULSE)
  ) u_coin (
    .clk_sys(clk_sys),
    .reset  (reset),
    .req    (coin_req),
    .pulse  (coin_pulse)
  );

  // Registered outputs with optional active-low polarity
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      btn_o  <= {BW{ACTIVE_LOW}};
      coin_o <= ACTIVE_LOW;
    end else begin
      btn_o  <= btn_n ^ {BW{ACTIVE_LOW}};
      coin_o <= coin_pulse ^ ACTIVE_LOW;
    end
  end

endmodule
